uart_tx_ctrl: RTL and testbench
===============================

# uart_tx_ctrl

Transmit-side controller for the UART. It drains the TX `fifo` (8-bit wide, 16 deep), popping one byte at a time and serialising each byte onto the `tx` line as an asynchronous frame: start bit, data bits LSB first, optional parity, stop bit(s). It owns the baud-rate timing and the frame state machine, and sits between the TX FIFO's `read_data`/`empty`/`pop` ports and the device pin.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per bit period (100 MHz / 115200); must be ≥ 2.
- `DATA_BITS`, default 8: data bits per frame (5–8); equals FIFO `width`.
- `PARITY_EN`, default 0: 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd parity (ignored when `PARITY_EN`=0).
- `STOP_BITS`, default 1: number of stop bits (1 or 2).

- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `enable`  in  1  permits starting new frames.
- `fifo_empty`  in  1  TX FIFO `empty`.
- `fifo_rdata`  in  DATA_BITS  TX FIFO `read_data`; valid whenever `fifo_empty`=0.
- `fifo_pop`  out  1  TX FIFO `pop`; one-cycle strobe per byte.
- `tx`  out  1  serial line; idle high.
- `busy`  out  1  frame in progress.
- `done`  out  1  one-cycle pulse per completed frame.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE → START:
  - Taken when `enable` && !`fifo_empty`.
  - `fifo_pop` is combinational and high in that same cycle.
  - `fifo_rdata` is latched into the shift register on that edge.
- START: `tx`=0 for CLKS_PER_BIT cycles → DATA.
- DATA:
  - `tx` = shift[0]; shift right once per bit period; DATA_BITS periods.
  - Exits to PARITY if PARITY_EN, otherwise to STOP.
- PARITY:
  - `tx` = ^data XOR PARITY_ODD for one bit period, using the data latched at pop.
  - → STOP.
- STOP: `tx`=1 for STOP_BITS×CLKS_PER_BIT cycles.
- At the last STOP cycle:
  - If `enable` && !`fifo_empty`, pop the next byte and go directly to START. Frames run back-to-back with no extra idle cycle.
  - Otherwise go to IDLE.
- Counters:
  - Bit-period counter counts 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT). It wraps to 0 at CLKS_PER_BIT-1 and is held at 0 in IDLE.
  - Bit index counter width is $clog2(DATA_BITS+1).
- `enable` deasserted mid-frame: the current frame completes and no further pop occurs.
- `fifo_pop` is never asserted when `fifo_empty`=1, nor in any state other than IDLE or the last STOP cycle.

## Timing
- Reset values: `tx`=1, `busy`=0, `done`=0, `fifo_pop`=0, state=IDLE, counters=0.
- `tx`, `busy` and `done` are registered.
- Latency: `tx` falls on the first edge after the pop cycle.
- Frame length is (1 + DATA_BITS + PARITY_EN + STOP_BITS) × CLKS_PER_BIT cycles, measured from the `tx` falling edge to the next possible start.
- `busy`: high from the edge after the pop through the last STOP cycle inclusive. It stays high continuously across back-to-back frames.
- `done`: high for exactly the one cycle following each frame's last STOP cycle, including between back-to-back frames.
- `rst` mid-frame:
  - Next edge forces the reset values; the partial frame is abandoned.
  - The popped byte is lost; the FIFO contents are untouched by this block.
- `rst` has priority over all other inputs.

## Structure
- Shared package `uart_pkg`:
  - state enum `tx_state_t` {IDLE, START, DATA, PARITY, STOP};
  - constant `UART_CLKS_PER_BIT_DEFAULT` = 868;
  - the parity-select constants.
- One sub-module, `uart_baud_cnt`:
  - bit-period counter with `clr` input and `tick` output, where `tick` is high on count CLKS_PER_BIT-1;
  - shared later with the RX side.

## Test plan
Bench setup: CLKS_PER_BIT=4.
- Single frame: FIFO holds 0xA5, `enable`=1.
  - One `fifo_pop` pulse.
  - `tx` sequence per 4-cycle period: 0, 1,0,1,0,0,1,0,1, 1.
  - `done` pulses 40 cycles after the `tx` falling edge; `busy` then drops.
- Back-to-back: FIFO holds 0x00, 0xFF.
  - Two pops exactly 40 cycles apart.
  - The stop bit lasts exactly 4 cycles before the second start bit.
  - `busy` never drops between frames; two `done` pulses.
- Parity: PARITY_EN=1, byte 0x07.
  - Even parity gives parity bit 1; with PARITY_ODD=1 it is 0.
  - Frame is 44 cycles.
- Empty and disable:
  - With `fifo_empty`=1, no pop and `tx` stays 1 for 100 cycles.
  - Dropping `enable` mid-frame completes that frame, with no further pop although the FIFO is non-empty.
- Reset mid-frame: assert `rst` during DATA bit 3.
  - Next edge: `tx`=1, `busy`=0, no `done`.
  - After release with FIFO 0x3C, a clean frame for 0x3C.
- STOP_BITS=2: the stop level lasts 8 cycles and the frame is 44 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, default timing and parity selection.
package uart_pkg;
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
   localparam int UART_CLKS_PER_BIT_DEFAULT = 868;
   localparam logic PARITY_EVEN_SEL = 1'b0;
   localparam logic PARITY_ODD_SEL = 1'b1;
   function automatic logic parity_bit(input logic [7:0] d, input logic sel);
      return ^d ^ sel;
   endfunction
endpackage

// File: rtl/uart_tx_ctrl_if.sv
// uart_tx_ctrl_if: TX FIFO read port as seen by the transmit controller.
interface uart_tx_ctrl_if #(parameter int DATA_BITS = 8);
   logic                 fifo_empty;
   logic [DATA_BITS-1:0] fifo_rdata;
   logic                 fifo_pop;
   modport master(input fifo_empty, fifo_rdata, output fifo_pop);
   modport slave(output fifo_empty, fifo_rdata, input fifo_pop);
endinterface

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: bit-period counter, tick on the last cycle of each period.
module uart_baud_cnt #(parameter int CLKS_PER_BIT = 868) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);
   localparam int W = $clog2(CLKS_PER_BIT);
   logic [W-1:0] cnt_q, cnt_d;
   always_comb begin
      tick = cnt_q == W'(CLKS_PER_BIT - 1);
      cnt_d = (clr || tick) ? '0 : cnt_q + 1'b1;
   end
   always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: drains the TX FIFO and serialises each byte as a UART frame.
module uart_tx_ctrl import uart_pkg::*; #(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
   parameter int DATA_BITS    = 8,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           enable,
   uart_tx_ctrl_if.master fifo,
   output logic           tx,
   output logic           busy,
   output logic           done
);
   localparam int BW = $clog2(DATA_BITS + 1);
   tx_state_t            state_q, state_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic                 par_q, par_d, tx_q, tx_d, busy_q, busy_d, done_q, done_d;
   logic                 tick, load, last_stop;
   uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
      .clk (clk),
      .rst (rst),
      .clr (state_q == IDLE),
      .tick(tick)
   );
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      bit_d = bit_q;
      par_d = par_q;
      last_stop = state_q == STOP && tick && bit_q == BW'(STOP_BITS - 1);
      load = !rst && enable && !fifo.fifo_empty && (state_q == IDLE || last_stop);
      if (load) begin
         shift_d = fifo.fifo_rdata;
         par_d = parity_bit(8'(fifo.fifo_rdata), PARITY_ODD != 0 ? PARITY_ODD_SEL : PARITY_EVEN_SEL);
      end
      case (state_q)
         IDLE:   state_d = load ? START : IDLE;
         START:  state_d = tick ? DATA : START;
         DATA: if (tick) begin
            shift_d = shift_q >> 1;
            bit_d = bit_q == BW'(DATA_BITS - 1) ? '0 : bit_q + 1'b1;
            if (bit_q == BW'(DATA_BITS - 1)) state_d = PARITY_EN != 0 ? PARITY : STOP;
         end
         PARITY: state_d = tick ? STOP : PARITY;
         STOP: if (tick) begin
            bit_d = last_stop ? '0 : bit_q + 1'b1;
            if (last_stop) state_d = load ? START : IDLE;
         end
         default: state_d = IDLE;
      endcase
      // tx/busy are registered from the next state so they line up with state_q
      tx_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : state_d == PARITY ? par_d : 1'b1;
      busy_d = state_d != IDLE;
      done_d = last_stop;
      fifo.fifo_pop = load;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         shift_q <= '0;
         bit_q <= '0;
         par_q <= 1'b0;
         tx_q <= 1'b1;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         bit_q <= bit_d;
         par_q <= par_d;
         tx_q <= tx_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end
   assign tx = tx_q;
   assign busy = busy_q;
   assign done = done_q;
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: directed checks of framing, back-to-back, parity, stop bits and reset.
module tb_uart_tx_ctrl;
   localparam int CPB = 4;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [3:0] en = '0;
   logic [3:0] tx, busy, done, pop;
   logic [7:0] q[4][$];
   logic [3:0] h[4][1024];
   int n = 0;
   int n_cmp = 0;
   int n_bad = 0;
   uart_tx_ctrl_if #(.DATA_BITS(8)) f0(), f1(), f2(), f3();
   always #5 clk = ~clk;
   assign pop = {f3.fifo_pop, f2.fifo_pop, f1.fifo_pop, f0.fifo_pop};
   uart_tx_ctrl #(.CLKS_PER_BIT(CPB)) d0 (.clk(clk), .rst(rst), .enable(en[0]), .fifo(f0),
      .tx(tx[0]), .busy(busy[0]), .done(done[0]));
   uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .PARITY_EN(1)) d1 (.clk(clk), .rst(rst), .enable(en[1]), .fifo(f1),
      .tx(tx[1]), .busy(busy[1]), .done(done[1]));
   uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1)) d2 (.clk(clk), .rst(rst), .enable(en[2]),
      .fifo(f2), .tx(tx[2]), .busy(busy[2]), .done(done[2]));
   uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) d3 (.clk(clk), .rst(rst), .enable(en[3]), .fifo(f3),
      .tx(tx[3]), .busy(busy[3]), .done(done[3]));
   function automatic logic [7:0] head(input int k);
      return q[k].size() != 0 ? q[k][0] : 8'h00;
   endfunction
   task automatic sync();
      f0.fifo_empty = q[0].size() == 0;
      f0.fifo_rdata = head(0);
      f1.fifo_empty = q[1].size() == 0;
      f1.fifo_rdata = head(1);
      f2.fifo_empty = q[2].size() == 0;
      f2.fifo_rdata = head(2);
      f3.fifo_empty = q[3].size() == 0;
      f3.fifo_rdata = head(3);
   endtask
   task automatic push(input int k, input logic [7:0] b);
      q[k].push_back(b);
      sync();
   endtask
   // sample at negedge (log bits: {pop,done,busy,tx}); FIFO pops one step after the edge
   task automatic step();
      logic [3:0] pp;
      @(negedge clk);
      pp = pop;
      for (int k = 0; k < 4; k++) h[k][n] = {pop[k], done[k], busy[k], tx[k]};
      n++;
      @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) if (pp[k] && q[k].size() != 0) void'(q[k].pop_front());
      sync();
   endtask
   task automatic run(input int c);
      repeat (c) step();
   endtask
   function automatic int cnt(input int k, input int kind, input int a, input int b);
      int c = 0;
      for (int i = a; i <= b; i++) c += int'(h[k][i][kind]);
      return c;
   endfunction
   function automatic int first(input int k, input int kind, input int a);
      for (int i = a; i < n; i++) if (h[k][i][kind]) return i;
      return -1;
   endfunction
   function automatic logic [63:0] txv(input int k, input int a, input int len);
      logic [63:0] r = '0;
      for (int i = 0; i < len; i++) r[i] = h[k][a+i][0];
      return r;
   endfunction
   function automatic logic [63:0] rep4(input logic [15:0] f, input int nb);
      logic [63:0] r = '0;
      for (int i = 0; i < nb * 4; i++) r[i] = f[i/4];
      return r;
   endfunction
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   initial begin
      sync();
      run(3);
      chk("rst_tx", 64'(h[0][2][0]), 1);
      chk("rst_busy", 64'(h[0][2][1]), 0);
      chk("rst_done", 64'(h[0][2][2]), 0);
      chk("rst_pop", 64'(h[0][2][3]), 0);
      rst = 1'b0;
      n = 0;
      en[0] = 1'b1;
      push(0, 8'hA5);
      run(60);
      chk("single_pop_idx", 64'(first(0, 3, 0)), 0);
      chk("single_pop_cnt", 64'(cnt(0, 3, 0, 59)), 1);
      chk("single_tx_idle", 64'(h[0][0][0]), 1);
      chk("single_frame", txv(0, 1, 40), rep4(16'h34A, 10));
      chk("single_done_idx", 64'(first(0, 2, 0)), 41);
      chk("single_done_cnt", 64'(cnt(0, 2, 0, 59)), 1);
      chk("single_busy_last", 64'(h[0][40][1]), 1);
      chk("single_busy_drop", 64'(h[0][41][1]), 0);
      n = 0;
      push(0, 8'h00);
      push(0, 8'hFF);
      run(100);
      chk("b2b_pop0", 64'(first(0, 3, 0)), 0);
      chk("b2b_pop1", 64'(first(0, 3, 1)), 40);
      chk("b2b_pop_cnt", 64'(cnt(0, 3, 0, 99)), 2);
      chk("b2b_frame0", txv(0, 1, 40), rep4(16'h200, 10));
      chk("b2b_frame1", txv(0, 41, 40), rep4(16'h3FE, 10));
      chk("b2b_busy", 64'(cnt(0, 1, 1, 80)), 80);
      chk("b2b_done0", 64'(first(0, 2, 0)), 41);
      chk("b2b_done1", 64'(first(0, 2, 42)), 81);
      chk("b2b_done_cnt", 64'(cnt(0, 2, 0, 99)), 2);
      n = 0;
      run(100);
      chk("empty_pop", 64'(cnt(0, 3, 0, 99)), 0);
      chk("empty_tx", 64'(cnt(0, 0, 0, 99)), 100);
      n = 0;
      push(0, 8'h11);
      push(0, 8'h22);
      push(0, 8'h33);
      run(10);
      en[0] = 1'b0;
      run(90);
      chk("dis_pop_cnt", 64'(cnt(0, 3, 0, 99)), 1);
      chk("dis_frame", txv(0, 1, 40), rep4(16'h222, 10));
      chk("dis_done_cnt", 64'(cnt(0, 2, 0, 99)), 1);
      chk("dis_fifo_left", 64'(q[0].size()), 2);
      q[0].delete();
      sync();
      en[0] = 1'b1;
      n = 0;
      push(0, 8'h5A);
      run(18);
      chk("rst_mid_bit3", 64'(h[0][17][0]), 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      chk("rst_mid_tx", 64'(h[0][19][0]), 1);
      chk("rst_mid_busy", 64'(h[0][19][1]), 0);
      chk("rst_mid_done", 64'(cnt(0, 2, 0, 19)), 0);
      chk("rst_mid_pop", 64'(h[0][19][3]), 0);
      n = 0;
      push(0, 8'h3C);
      run(60);
      chk("rst_after_frame", txv(0, 1, 40), rep4(16'h278, 10));
      chk("rst_after_done", 64'(first(0, 2, 0)), 41);
      chk("rst_after_pop", 64'(cnt(0, 3, 0, 59)), 1);
      en[0] = 1'b0;
      en[1] = 1'b1;
      en[2] = 1'b1;
      en[3] = 1'b1;
      n = 0;
      push(1, 8'h07);
      push(2, 8'h07);
      push(3, 8'h96);
      run(60);
      chk("par_even_frame", txv(1, 1, 44), rep4(16'h60E, 11));
      chk("par_even_done", 64'(first(1, 2, 0)), 45);
      chk("par_even_pop", 64'(cnt(1, 3, 0, 59)), 1);
      chk("par_odd_frame", txv(2, 1, 44), rep4(16'h40E, 11));
      chk("par_odd_done", 64'(first(2, 2, 0)), 45);
      chk("stop2_frame", txv(3, 1, 44), rep4(16'h72C, 11));
      chk("stop2_done", 64'(first(3, 2, 0)), 45);
      chk("stop2_busy_last", 64'(h[3][44][1]), 1);
      chk("stop2_busy_drop", 64'(h[3][45][1]), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
